// File: rtl/mem_port_arbiter.sv
// Two-requester memory port arbiter: instruction fetch vs. data access.
// Data wins by default; fetch is forced after STREAK_MAX data grants made while a fetch waited.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT    = 15,
  parameter int unsigned STREAK_MAX = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic        if_flush,
  input  logic [63:0] if_addr,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [63:0] d_addr,
  input  logic [63:0] d_wdata,
  input  logic [1:0]  d_size,
  input  logic        mem_ready,
  input  logic [63:0] mem_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic [1:0]  mem_size,
  output logic        if_done,
  output logic        d_done,
  output logic        err,
  output logic [31:0] if_rdata,
  output logic [63:0] d_rdata,
  output logic        stall_if,
  output logic        stall_mem
);

  localparam int unsigned ToW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam int unsigned StW = (STREAK_MAX < 1) ? 1 : $clog2(STREAK_MAX + 1);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_D, RESP} state_t;

  state_t         state, stateNext;
  logic [ToW-1:0] toCnt;
  logic [StW-1:0] streak;
  logic [63:0]    latAddr, latWdata;
  logic           latWe;
  logic [1:0]     latSize;
  logic           respFetch, flushSeen;
  logic [31:0]    ifRdataQ;
  logic [63:0]    dRdataQ;
  logic           errQ;

  logic fetchWant, pickData, pickFetch, busy, timedOut;

  // A flushing fetch is not a contender, so it neither wins nor forces a streak break.
  assign fetchWant = if_req & ~if_flush;
  assign pickData  = d_req & ~(fetchWant & (streak == StW'(STREAK_MAX)));
  assign pickFetch = fetchWant & ~pickData;
  assign busy      = (state == BUSY_IF) || (state == BUSY_D);
  assign timedOut  = (toCnt == ToW'(TIMEOUT - 1));

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE: begin
        if (pickData)       stateNext = BUSY_D;
        else if (pickFetch) stateNext = BUSY_IF;
      end
      BUSY_IF, BUSY_D: begin
        if (mem_ready)     stateNext = RESP;
        else if (timedOut) stateNext = IDLE;
      end
      RESP:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      toCnt     <= '0;
      streak    <= '0;
      latAddr   <= '0;
      latWdata  <= '0;
      latWe     <= 1'b0;
      latSize   <= '0;
      respFetch <= 1'b0;
      flushSeen <= 1'b0;
      ifRdataQ  <= '0;
      dRdataQ   <= '0;
      errQ      <= 1'b0;
    end else begin
      state <= stateNext;
      errQ  <= 1'b0;
      unique case (state)
        IDLE: begin
          toCnt     <= '0;
          flushSeen <= 1'b0;
          if (pickData) begin
            latAddr   <= d_addr;
            latWdata  <= d_wdata;
            latWe     <= d_we;
            latSize   <= d_size;
            respFetch <= 1'b0;
            if (!fetchWant)                         streak <= '0;
            else if (streak != StW'(STREAK_MAX))    streak <= streak + 1'b1;
          end else if (pickFetch) begin
            latAddr   <= if_addr;
            latWdata  <= '0;
            latWe     <= 1'b0;
            latSize   <= 2'b10;
            respFetch <= 1'b1;
            streak    <= '0;
          end
        end
        BUSY_IF, BUSY_D: begin
          if (state == BUSY_IF && if_flush) flushSeen <= 1'b1;
          if (mem_ready) begin
            if (state == BUSY_D)                 dRdataQ  <= mem_rdata;
            else if (!flushSeen && !if_flush)    ifRdataQ <= mem_rdata[31:0];
          end else if (timedOut) begin
            errQ <= 1'b1;
          end else begin
            toCnt <= toCnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_req   = busy;
  assign mem_we    = busy ? latWe    : 1'b0;
  assign mem_addr  = busy ? latAddr  : '0;
  assign mem_wdata = busy ? latWdata : '0;
  assign mem_size  = busy ? latSize  : '0;

  assign if_done   = (state == RESP) & respFetch & ~flushSeen & ~if_flush;
  assign d_done    = (state == RESP) & ~respFetch;
  assign err       = errQ;
  assign if_rdata  = ifRdataQ;
  assign d_rdata   = dRdataQ;

  assign stall_if  = if_req & ~if_done & ~if_flush;
  assign stall_mem = d_req & ~d_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios with literal expectations, then a long
// randomized run, all continuously compared against a transaction-level model.
module tb_mem_port_arbiter;
  localparam int TO = 15;
  localparam int SM = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        if_req = 1'b0, if_flush = 1'b0, d_req = 1'b0, d_we = 1'b0, mem_ready = 1'b0;
  logic [63:0] if_addr = '0, d_addr = '0, d_wdata = '0, mem_rdata = '0;
  logic [1:0]  d_size = '0;
  logic        mem_req, mem_we, if_done, d_done, err, stall_if, stall_mem;
  logic [63:0] mem_addr, mem_wdata, d_rdata;
  logic [1:0]  mem_size;
  logic [31:0] if_rdata;

  mem_port_arbiter #(.TIMEOUT(TO), .STREAK_MAX(SM)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_flush(if_flush), .if_addr(if_addr),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_size(d_size),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_size(mem_size), .if_done(if_done), .d_done(d_done), .err(err),
    .if_rdata(if_rdata), .d_rdata(d_rdata), .stall_if(stall_if), .stall_mem(stall_mem)
  );

  always #5 clk = ~clk;

  int nTests = 0;
  int nFail  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: one outstanding access record plus a response slot.
  bit          mActive, mActFetch, mFlushed, mResp, mRespFetch, mRespFlushed, mErr;
  int          mWait, mStreak;
  logic [63:0] mAddr, mWdata;
  logic        mWe;
  logic [1:0]  mSize;
  logic [31:0] mIfRdata;
  logic [63:0] mDRdata;
  bit          checkEn = 0;
  bit          lastIfDone, lastDDone;

  always @(posedge clk) begin : model
    bit fw;
    bit tout;
    tout = 0;
    if (!reset) begin
      mActive = 0; mResp = 0; mFlushed = 0; mStreak = 0; mWait = 0;
      mIfRdata = '0; mDRdata = '0;
    end else if (mResp) begin
      mResp = 0;
    end else if (mActive) begin
      if (mem_ready) begin
        mRespFetch = mActFetch;
        if (mActFetch) begin
          mRespFlushed = mFlushed || if_flush;
          if (!mRespFlushed) mIfRdata = mem_rdata[31:0];
        end else begin
          mDRdata = mem_rdata;
        end
        mActive = 0;
        mResp = 1;
      end else begin
        if (mActFetch && if_flush) mFlushed = 1;
        mWait++;
        if (mWait == TO) begin
          mActive = 0;
          tout = 1;
        end
      end
    end else begin
      fw = if_req && !if_flush;
      mWait = 0;
      mFlushed = 0;
      if (d_req && !(fw && mStreak == SM)) begin
        mActive = 1; mActFetch = 0;
        mAddr = d_addr; mWdata = d_wdata; mWe = d_we; mSize = d_size;
        mStreak = fw ? ((mStreak < SM) ? mStreak + 1 : SM) : 0;
      end else if (fw) begin
        mActive = 1; mActFetch = 1;
        mAddr = if_addr; mWdata = '0; mWe = 0; mSize = 2'b10;
        mStreak = 0;
      end
    end
    mErr = tout;
  end

  always @(negedge clk) begin : compare
    bit eIfDone, eDDone;
    eIfDone = mResp && mRespFetch && !mRespFlushed && !if_flush;
    eDDone  = mResp && !mRespFetch;
    lastIfDone = eIfDone;
    lastDDone  = eDDone;
    if (checkEn) begin
      chk("mem_req",   mem_req,   mActive);
      chk("mem_we",    mem_we,    mActive ? mWe : 1'b0);
      chk("mem_addr",  mem_addr,  mActive ? mAddr : 64'd0);
      chk("mem_wdata", mem_wdata, mActive ? mWdata : 64'd0);
      chk("mem_size",  mem_size,  mActive ? mSize : 2'd0);
      chk("if_done",   if_done,   eIfDone);
      chk("d_done",    d_done,    eDDone);
      chk("err",       err,       mErr);
      chk("if_rdata",  if_rdata,  mIfRdata);
      chk("d_rdata",   d_rdata,   mDRdata);
      chk("stall_if",  stall_if,  if_req && !eIfDone && !if_flush);
      chk("stall_mem", stall_mem, d_req && !eDDone);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic waitGrant(input string nm);
    bit got;
    got = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_req) begin
        got = 1;
        break;
      end
    end
    chk({nm, "_grant_seen"}, got, 1'b1);
  endtask

  task automatic serveOne(input string nm, output logic we, output logic [63:0] addr,
                          output logic [1:0] size);
    waitGrant(nm);
    we = mem_we;
    addr = mem_addr;
    size = mem_size;
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
  endtask

  initial begin
    logic        we;
    logic [63:0] addr;
    logic [1:0]  size;
    int busyCnt, errCnt, doneCnt, pct;

    // Reset state
    tick();
    checkEn = 1;
    tick();
    @(negedge clk);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_if_rdata", if_rdata, 64'd0);
    chk("rst_d_rdata", d_rdata, 64'd0);
    chk("rst_err", err, 1'b0);
    chk("rst_dones", {if_done, d_done}, 2'b00);

    // Basic fetch, minimum latency
    @(posedge clk); #1;
    reset = 1'b1; if_req = 1'b1; if_addr = 64'h100;
    tick();
    mem_ready = 1'b1; mem_rdata = 64'hDEAD_BEEF_0000_0013;
    @(negedge clk);
    chk("f_mem_addr", mem_addr, 64'h100);
    chk("f_mem_size", mem_size, 2'b10);
    chk("f_done_early", if_done, 1'b0);
    tick();
    mem_ready = 1'b0;
    @(negedge clk);
    chk("f_if_done_n2", if_done, 1'b1);
    chk("f_if_rdata", if_rdata, 64'h13);
    tick();
    if_req = 1'b0;

    // Streak: data, data, then forced fetch
    if_req = 1'b1; if_addr = 64'h300;
    d_req = 1'b1; d_we = 1'b1; d_addr = 64'h2000; d_wdata = 64'h5A5A; d_size = 2'b11;
    mem_rdata = 64'h1111_2222_3333_0055;
    serveOne("s1", we, addr, size);
    chk("s1_we", we, 1'b1);
    chk("s1_addr", addr, 64'h2000);
    serveOne("s2", we, addr, size);
    chk("s2_we", we, 1'b1);
    serveOne("s3", we, addr, size);
    chk("s3_we", we, 1'b0);
    chk("s3_addr", addr, 64'h300);
    chk("s3_size", size, 2'b10);
    if_req = 1'b0; d_req = 1'b0;
    tick();
    @(negedge clk);
    chk("s_d_rdata", d_rdata, 64'h1111_2222_3333_0055);
    chk("s_if_rdata", if_rdata, 64'h3333_0055);

    // Timeout
    @(posedge clk); #1;
    d_req = 1'b1; d_we = 1'b0; d_addr = 64'h600;
    busyCnt = 0; errCnt = 0; doneCnt = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (mem_req) busyCnt++;
      if (d_done) doneCnt++;
      if (err) begin
        errCnt++;
        d_req = 1'b0;
      end
    end
    chk("to_busy_cycles", busyCnt, 64'd15);
    chk("to_err_pulses", errCnt, 64'd1);
    chk("to_no_done", doneCnt, 64'd0);

    // Flush during fetch
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 64'h400;
    waitGrant("fl");
    if_flush = 1'b1;
    #1;
    chk("fl_stall_if", stall_if, 1'b0);
    tick();
    @(negedge clk);
    chk("fl_mem_req_held", mem_req, 1'b1);
    mem_ready = 1'b1; mem_rdata = 64'hAAAA_BBBB_CCCC_DDDD;
    tick();
    mem_ready = 1'b0; if_flush = 1'b0; if_req = 1'b0;
    @(negedge clk);
    chk("fl_no_if_done", if_done, 1'b0);
    chk("fl_if_rdata_kept", if_rdata, 64'h3333_0055);
    tick();

    // Reset in the middle of a data access
    d_req = 1'b1; d_we = 1'b1; d_addr = 64'h500; d_wdata = 64'h77;
    waitGrant("mr");
    reset = 1'b0;
    tick();
    reset = 1'b1;
    @(negedge clk);
    chk("mr_mem_req", mem_req, 1'b0);
    chk("mr_mem_addr", mem_addr, 64'd0);
    chk("mr_d_done", d_done, 1'b0);
    chk("mr_d_rdata", d_rdata, 64'd0);
    chk("mr_if_rdata", if_rdata, 64'd0);
    waitGrant("mr2");
    chk("mr2_addr", mem_addr, 64'h500);
    chk("mr2_we", mem_we, 1'b1);
    mem_ready = 1'b1; mem_rdata = 64'h99;
    tick();
    mem_ready = 1'b0; d_req = 1'b0;
    @(negedge clk);
    chk("mr2_d_done", d_done, 1'b1);
    chk("mr2_d_rdata", d_rdata, 64'h99);
    tick();

    // mem_ready while idle
    mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_rdy_req", mem_req, 1'b0);
      chk("idle_rdy_done", {if_done, d_done}, 2'b00);
    end
    tick();
    mem_ready = 1'b0;

    // Randomized traffic, checked by the model each cycle
    pct = 35;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      tick();
      if (cyc % 200 == 0) pct = (cyc % 600 == 200) ? 0 : ((cyc % 600 == 400) ? 60 : 35);
      reset = (reset == 1'b0) ? 1'b1 : ($urandom_range(149) != 0);
      if (if_req && (lastIfDone || if_flush)) if_req = 1'b0;
      else if (!if_req && $urandom_range(3) == 0) begin
        if_req = 1'b1;
        if_addr = {$urandom, $urandom};
      end
      if_flush = if_req && ($urandom_range(19) == 0);
      if (d_req && lastDDone) d_req = 1'b0;
      else if (!d_req && $urandom_range(3) == 0) begin
        d_req = 1'b1;
        d_we = $urandom_range(1);
        d_addr = {$urandom, $urandom};
        d_wdata = {$urandom, $urandom};
        d_size = 2'($urandom_range(3));
      end
      mem_ready = ($urandom_range(99) < pct);
      mem_rdata = {$urandom, $urandom};
    end
    if_req = 1'b0; d_req = 1'b0; if_flush = 1'b0; mem_ready = 1'b0; reset = 1'b1;
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
endmodule
